// File: rtl/adc_trigger_pkg.sv
// rtl/adc_trigger_pkg.sv - mode and state encodings for the ADC trigger sequencer
package adc_trigger_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_EXT    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_STOP  = 2'b11
    } state_e;

endpackage

// File: rtl/adc_trigger_seq_if.sv
// rtl/adc_trigger_seq_if.sv - configuration, ADC/DMA status and sequencer outputs
interface adc_trigger_seq_if #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0]   divider;
    logic [BURST_W-1:0] burst_len;
    logic [1:0]         mode;
    logic               arm;
    logic               abort;
    logic               ext_trig;
    logic               busy;
    logic               last;
    logic               ready;
    logic               cnv;
    logic               trigger;
    logic [CH_W-1:0]    ch_sel;
    logic [CH_W-1:0]    acq_ch;
    logic               running;
    logic [BURST_W-1:0] sample_count;

    modport master (
        output divider, burst_len, mode, arm, abort, ext_trig, busy, last, ready,
        input  cnv, trigger, ch_sel, acq_ch, running, sample_count
    );

    modport slave (
        input  divider, burst_len, mode, arm, abort, ext_trig, busy, last, ready,
        output cnv, trigger, ch_sel, acq_ch, running, sample_count
    );

endinterface

// File: rtl/adc_trigger_acq.sv
// rtl/adc_trigger_acq.sv - busy edge detection, pending flag and channel tag for acquisition
module adc_trigger_acq #(
    parameter int CH_W = 2
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            clear,
    input  logic            cnv,
    input  logic [CH_W-1:0] ch_sel,
    input  logic            busy,
    input  logic            ready,
    output logic            trigger,
    output logic [CH_W-1:0] acq_ch
);
    logic            busy_q;
    logic            pending_q;
    logic            acq_trg_q;
    logic [CH_W-1:0] cur_ch_q;
    logic [CH_W-1:0] conv_ch_q;
    logic [CH_W-1:0] acq_ch_q;
    logic            busy_rise;
    logic            busy_fall;

    assign busy_rise = busy & ~busy_q;
    assign busy_fall = ~busy & busy_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            acq_trg_q <= 1'b0;
            cur_ch_q  <= '0;
            conv_ch_q <= '0;
            acq_ch_q  <= '0;
        end else begin
            busy_q    <= busy;
            acq_trg_q <= 1'b0;
            if (cnv) begin
                cur_ch_q <= ch_sel;
            end
            // The falling edge tags the finished conversion; the next rising edge releases it.
            if (clear) begin
                pending_q <= 1'b0;
            end else if (busy_fall) begin
                pending_q <= 1'b1;
                conv_ch_q <= cur_ch_q;
            end else if (busy_rise && pending_q) begin
                pending_q <= 1'b0;
                acq_trg_q <= 1'b1;
                acq_ch_q  <= conv_ch_q;
            end
        end
    end

    assign trigger = acq_trg_q & ready;
    assign acq_ch  = acq_ch_q;

endmodule

// File: rtl/adc_trigger_seq.sv
// rtl/adc_trigger_seq.sv - ADC conversion strobe sequencer with burst, channel stepping and acquisition trigger
module adc_trigger_seq
    import adc_trigger_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    adc_trigger_seq_if.slave  bus
);
    localparam int              CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BURST_W-1:0] samp_q, samp_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               ext_q;
    logic               ext_rise_q;
    logic               clear;
    logic               div_on;
    logic               cnv;
    logic               burst_done;
    logic               start_run;
    logic               mode_single;
    logic               mode_cont;
    logic               mode_ext;

    assign mode_single = (bus.mode == MODE_SINGLE);
    assign mode_cont   = (bus.mode == MODE_CONT);
    assign mode_ext    = (bus.mode == MODE_EXT);
    assign clear       = bus.abort | (bus.mode == MODE_RSVD);
    assign div_on      = (bus.divider != '0);
    assign cnv         = (state_q == ST_RUN) & div_on & (count_q == bus.divider) & bus.ready;
    assign burst_done  = cnv & (bus.burst_len != '0) & (samp_q == bus.burst_len - BURST_W'(1));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        samp_d    = samp_q;
        ch_d      = ch_q;
        start_run = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            ch_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_cont || (mode_single && bus.arm)) begin
                        start_run = 1'b1;
                    end else if (mode_ext && bus.arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: start_run = ext_rise_q;
                ST_RUN: begin
                    // Wrapping on counter >= divider lets a lowered divider take effect at once.
                    count_d = (div_on && (count_q < bus.divider)) ? count_q + CNT_W'(1) : '0;
                    if (cnv) begin
                        samp_d = samp_q + BURST_W'(1);
                        ch_d   = (ch_q == CH_MAX) ? '0 : ch_q + CH_W'(1);
                    end
                    if (mode_cont) begin
                        if (burst_done) begin
                            samp_d = '0;
                        end
                    end else if (burst_done || bus.last) begin
                        count_d = '0;
                        state_d = mode_ext ? ST_ARMED : ST_STOP;
                    end
                end
                ST_STOP: start_run = mode_cont || (mode_single && bus.arm);
                default: state_d = ST_IDLE;
            endcase
            if (start_run) begin
                state_d = ST_RUN;
                count_d = '0;
                samp_d  = '0;
                ch_d    = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            samp_q     <= '0;
            ch_q       <= '0;
            ext_q      <= 1'b0;
            ext_rise_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            samp_q     <= samp_d;
            ch_q       <= ch_d;
            ext_q      <= bus.ext_trig;
            ext_rise_q <= bus.ext_trig & ~ext_q;
        end
    end

    adc_trigger_acq #(.CH_W(CH_W)) u_acq (
        .aclk    (aclk),
        .areset  (areset),
        .clear   (clear),
        .cnv     (cnv),
        .ch_sel  (ch_q),
        .busy    (bus.busy),
        .ready   (bus.ready),
        .trigger (bus.trigger),
        .acq_ch  (bus.acq_ch)
    );

    assign bus.cnv          = cnv;
    assign bus.ch_sel       = ch_q;
    assign bus.running      = (state_q == ST_RUN);
    assign bus.sample_count = samp_q;

endmodule

// File: tb/tb_adc_trigger_seq.sv
// tb/tb_adc_trigger_seq.sv - scoreboard bench for adc_trigger_seq
module tb_adc_trigger_seq;
    import adc_trigger_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;
    localparam int K_RUN = 0, K_SAMP = 1, K_CH = 2, K_ACQ = 3, K_CNV = 4, K_TRG = 5;

    typedef struct { int cyc; int ch; } ev_t;
    typedef struct { int cyc; int kind; int val; } st_t;

    logic aclk = 1'b0;
    logic areset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    ev_t cnv_q[$];
    ev_t trg_q[$];
    st_t st_q[$];

    adc_trigger_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    adc_trigger_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    function automatic string kname(int k);
        case (k)
            K_RUN:   return "running";
            K_SAMP:  return "sample_count";
            K_CH:    return "ch_sel";
            K_ACQ:   return "acq_ch";
            K_CNV:   return "cnv";
            default: return "trigger";
        endcase
    endfunction

    function automatic int sample_sig(int k);
        case (k)
            K_RUN:   return int'(bus.running);
            K_SAMP:  return int'(bus.sample_count);
            K_CH:    return int'(bus.ch_sel);
            K_ACQ:   return int'(bus.acq_ch);
            K_CNV:   return int'(bus.cnv);
            default: return int'(bus.trigger);
        endcase
    endfunction

    // Monitor: the only process that counts comparisons.
    initial begin
        forever begin
            @(negedge aclk);
            while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
                st_t s;
                int  act;
                s   = st_q.pop_front();
                act = sample_sig(s.kind);
                total++;
                if (act != s.val || s.cyc != cyc) begin
                    bad++;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d (due cycle %0d)",
                             kname(s.kind), cyc, act, s.val, s.cyc);
                end
            end
            while (cnv_q.size() > 0 && cnv_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL cnv_missing: expected cnv at cycle %0d ch %0d, got no strobe", cnv_q[0].cyc, cnv_q[0].ch);
                void'(cnv_q.pop_front());
            end
            if (bus.cnv) begin
                total++;
                if (cnv_q.size() == 0) begin
                    bad++;
                    $display("FAIL cnv_unexpected at cycle %0d ch %0d, expected none", cyc, bus.ch_sel);
                end else begin
                    ev_t e;
                    e = cnv_q.pop_front();
                    if (e.cyc != cyc || e.ch != int'(bus.ch_sel)) begin
                        bad++;
                        $display("FAIL cnv: got cycle %0d ch %0d, expected cycle %0d ch %0d", cyc, bus.ch_sel, e.cyc, e.ch);
                    end
                end
            end
            while (trg_q.size() > 0 && trg_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL trigger_missing: expected trigger at cycle %0d ch %0d, got no pulse", trg_q[0].cyc, trg_q[0].ch);
                void'(trg_q.pop_front());
            end
            if (bus.trigger) begin
                total++;
                if (trg_q.size() == 0) begin
                    bad++;
                    $display("FAIL trigger_unexpected at cycle %0d acq_ch %0d, expected none", cyc, bus.acq_ch);
                end else begin
                    ev_t e;
                    e = trg_q.pop_front();
                    if (e.cyc != cyc || e.ch != int'(bus.acq_ch)) begin
                        bad++;
                        $display("FAIL trigger: got cycle %0d acq_ch %0d, expected cycle %0d acq_ch %0d", cyc, bus.acq_ch, e.cyc, e.ch);
                    end
                end
            end
            if (done) begin
                total++;
                if (cnv_q.size() + trg_q.size() + st_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover_expectations: got %0d pending, expected 0", cnv_q.size() + trg_q.size() + st_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_to(int n);
        while (cyc < n) tick();
    endtask

    task automatic go_idle();
        bus.abort    = 1'b1;
        bus.mode     = MODE_SINGLE;
        bus.arm      = 1'b0;
        bus.last     = 1'b0;
        bus.busy     = 1'b0;
        bus.ready    = 1'b1;
        bus.ext_trig = 1'b0;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask

    task automatic push_st(int c, int k, int v);
        st_q.push_back('{c, k, v});
    endtask

    // Conversions of one run entered at cycle r: k-th strobe lands at r + d + k*(d+1).
    task automatic push_run(int r, int d, int n);
        for (int k = 0; k < n; k++) cnv_q.push_back('{r + d + k * (d + 1), k % NUM_CH});
    endtask

    initial begin
        int d, b, m, a, e, tl, te, n, j, t0, nis, rlo, rhi;
        int tcs[8];
        int ps[7];
        int pw[7];
        int iss_t[8];

        areset        = 1'b1;
        bus.divider   = '0;
        bus.burst_len = '0;
        bus.mode      = MODE_SINGLE;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.ext_trig  = 1'b0;
        bus.busy      = 1'b0;
        bus.last      = 1'b0;
        bus.ready     = 1'b1;
        for (int k = 0; k < 6; k++) push_st(2, k, 0);
        wait_to(4);
        areset = 1'b0;
        tick();

        // Continuous mode with random divider/burst; last must be ignored.
        go_idle();
        d = $urandom_range(2, 6);
        b = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 5);
        n = 7;
        bus.divider   = CNT_W'(d);
        bus.burst_len = BURST_W'(b);
        m = cyc;
        bus.mode = MODE_CONT;
        push_run(m + 1, d, n);
        tl = m + 1 + d + (n - 1) * (d + 1);
        push_st(tl + 1, K_RUN, 1);
        push_st(tl + 1, K_SAMP, (b != 0) ? n % b : n);
        push_st(tl + 1, K_CH, n % NUM_CH);
        while (cyc < tl + 1) begin
            bus.last = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.last  = 1'b0;
        bus.abort = 1'b1;
        bus.mode  = MODE_SINGLE;
        push_st(tl + 2, K_RUN, 0);
        push_st(tl + 2, K_CH, 0);
        push_st(tl + 2, K_SAMP, (b != 0) ? n % b : n);
        tick();
        bus.abort = 1'b0;

        // Single-shot burst, re-armed from STOP; an arm inside RUN is ignored.
        go_idle();
        d = $urandom_range(1, 5);
        b = $urandom_range(1, 4);
        bus.divider   = CNT_W'(d);
        bus.burst_len = BURST_W'(b);
        for (int r = 0; r < 2; r++) begin
            a = cyc;
            bus.arm = 1'b1;
            push_run(a + 1, d, b);
            te = a + 1 + d + (b - 1) * (d + 1);
            push_st(te + 1, K_RUN, 0);
            push_st(te + 1, K_SAMP, b);
            tick();
            bus.arm = 1'b0;
            if (r == 1) begin
                tick();
                bus.arm = 1'b1;
                tick();
                bus.arm = 1'b0;
            end
            wait_to(te + 3);
        end

        // External trigger: two bursts, each re-armed automatically.
        go_idle();
        d = $urandom_range(1, 4);
        b = $urandom_range(1, 3);
        bus.divider   = CNT_W'(d);
        bus.burst_len = BURST_W'(b);
        bus.mode      = MODE_EXT;
        bus.arm       = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_to(cyc + $urandom_range(1, 3));
            e = cyc;
            bus.ext_trig = 1'b1;
            push_run(e + 2, d, b);
            te = e + 2 + d + (b - 1) * (d + 1);
            push_st(e + 1, K_RUN, 0);
            push_st(e + 2, K_RUN, 1);
            push_st(te + 1, K_RUN, 0);
            tick();
            tick();
            bus.ext_trig = 1'b0;
            wait_to(te + 2);
        end

        // Unlimited single-shot run ended by last coincident with a terminal count.
        go_idle();
        d = $urandom_range(2, 4);
        j = $urandom_range(1, 3);
        bus.divider   = CNT_W'(d);
        bus.burst_len = '0;
        a = cyc;
        bus.arm = 1'b1;
        push_run(a + 1, d, j + 1);
        te = a + 1 + d + j * (d + 1);
        push_st(te + 1, K_RUN, 0);
        push_st(te + 1, K_SAMP, j + 1);
        tick();
        bus.arm = 1'b0;
        wait_to(te);
        bus.last = 1'b1;
        tick();
        bus.last = 1'b0;
        wait_to(te + 3);

        // Acquisition tagging with a ready-low window that suppresses strobes and one trigger.
        go_idle();
        d = 6;
        bus.divider   = CNT_W'(d);
        bus.burst_len = '0;
        m = cyc;
        bus.mode = MODE_CONT;
        for (int k = 0; k < 8; k++) tcs[k] = m + 1 + d + k * (d + 1);
        rlo = tcs[4] + 3;
        rhi = tcs[6] + 2;
        nis = 0;
        for (int k = 0; k < 8; k++) begin
            if (tcs[k] < rlo || tcs[k] > rhi) begin
                iss_t[nis] = tcs[k];
                cnv_q.push_back('{tcs[k], nis % NUM_CH});
                nis++;
            end
        end
        for (int p = 0; p < 6; p++) ps[p] = tcs[p] + 1;
        ps[6] = tcs[7] + 1;
        for (int p = 0; p < 7; p++) pw[p] = $urandom_range(1, 3);
        for (int p = 1; p < 7; p++) begin
            int t, fall, lch;
            t    = ps[p] + 1;
            fall = ps[p - 1] + pw[p - 1];
            lch  = 0;
            for (int i = 0; i < nis; i++) if (iss_t[i] < fall) lch = i % NUM_CH;
            if (t < rlo || t > rhi) trg_q.push_back('{t, lch});
        end
        push_st(tcs[6] + 1, K_SAMP, 5);
        push_st(tcs[7] + 1, K_SAMP, 6);
        tick();
        while (cyc < tcs[7] + 6) begin
            bus.ready = !(cyc >= rlo && cyc <= rhi);
            bus.busy  = 1'b0;
            for (int p = 0; p < 7; p++) if (cyc >= ps[p] && cyc < ps[p] + pw[p]) bus.busy = 1'b1;
            tick();
        end
        bus.busy  = 1'b0;
        bus.ready = 1'b1;

        // Abort with an acquisition pending: no trigger on the following busy rise.
        go_idle();
        bus.divider   = CNT_W'(5);
        bus.burst_len = '0;
        m = cyc;
        bus.mode = MODE_CONT;
        t0 = m + 6;
        cnv_q.push_back('{t0, 0});
        push_st(t0 + 5, K_RUN, 0);
        push_st(t0 + 5, K_SAMP, 1);
        push_st(t0 + 5, K_CH, 0);
        tick();
        while (cyc < t0 + 11) begin
            bus.busy  = (cyc == t0 + 1 || cyc == t0 + 2 || cyc == t0 + 7 || cyc == t0 + 8);
            bus.abort = (cyc == t0 + 4);
            if (cyc == t0 + 4) bus.mode = MODE_SINGLE;
            tick();
        end
        bus.busy  = 1'b0;
        bus.abort = 1'b0;

        // Divider lowered 10 -> 3 with the counter at 7, then reserved mode forces IDLE.
        go_idle();
        bus.divider   = CNT_W'(10);
        bus.burst_len = '0;
        m = cyc;
        bus.mode = MODE_CONT;
        cnv_q.push_back('{m + 12, 0});
        cnv_q.push_back('{m + 16, 1});
        wait_to(m + 8);
        bus.divider = CNT_W'(3);
        wait_to(m + 18);
        bus.mode = MODE_RSVD;
        push_st(m + 19, K_RUN, 0);
        push_st(m + 19, K_CH, 0);
        tick();
        tick();

        go_idle();
        tick();
        done = 1'b1;
    end

endmodule
